// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use stall and branch/jump flush; 1-cycle latency.
// A stall holds the PC and IF/ID, injecting a bubble into ID/EX. IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter logic [31:0] PC_RST   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] PC_i,
    input  logic [31:0] inst_i,
    input  logic        flush_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_rt_i,
    output logic [31:0] PC_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic [5:0]  op_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        stall_o,
    output logic        PCWrite_o,
    output logic        bubble_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic reads_rs;
    logic reads_rt;

    assign op_o  = inst_o[31:26];
    assign rs_o  = inst_o[25:21];
    assign rt_o  = inst_o[20:16];
    assign rd_o  = inst_o[15:11];
    assign imm_o = {{16{inst_o[15]}}, inst_o[15:0]};

    // rt is only a source operand for R-type, store data and beq compare.
    always_comb begin
        reads_rs = (op_o != OP_J);
        reads_rt = (op_o == OP_RTYPE) || (op_o == OP_SW) || (op_o == OP_BEQ);
        stall_o  = valid_o && IDEX_MemRead_i && (IDEX_rt_i != 5'd0) &&
                   (((IDEX_rt_i == rs_o) && reads_rs) ||
                    ((IDEX_rt_i == rt_o) && reads_rt));
    end

    assign PCWrite_o = ~stall_o;
    assign bubble_o  = stall_o | ~valid_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inst_o  <= NOP_INST;
            PC_o    <= PC_RST;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            inst_o  <= NOP_INST;
            PC_o    <= PC_i;
            valid_o <= 1'b0;
        end else if (!stall_o) begin
            inst_o  <= inst_i;
            PC_o    <= PC_i;
            valid_o <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    // Saturating so long-running profiles never wrap back to a misleading small value.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= 16'd0;
            flush_cnt_o <= 16'd0;
        end else begin
            if (stall_o && !flush_i && (stall_cnt_o != 16'hFFFF))
                stall_cnt_o <= stall_cnt_o + 16'd1;
            if (flush_i && (flush_cnt_o != 16'hFFFF))
                flush_cnt_o <= flush_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] PC_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_rt_i;
    logic [31:0] PC_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic [5:0]  op_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  rd_o;
    logic [31:0] imm_o;
    logic        stall_o;
    logic        PCWrite_o;
    logic        bubble_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    if_id_stage dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .PC_i           (PC_i),
        .inst_i         (inst_i),
        .flush_i        (flush_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_rt_i      (IDEX_rt_i),
        .PC_o           (PC_o),
        .inst_o         (inst_o),
        .valid_o        (valid_o),
        .op_o           (op_o),
        .rs_o           (rs_o),
        .rt_o           (rt_o),
        .rd_o           (rd_o),
        .imm_o          (imm_o),
        .stall_o        (stall_o),
        .PCWrite_o      (PCWrite_o),
        .bubble_o       (bubble_o)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference hazard rule: which registers does the held instruction read?
    function automatic bit ref_hazard(input logic [31:0] inst, input bit v,
                                      input bit mr, input logic [4:0] r);
        int op, src_rs, src_rt;
        bit uses_rs, uses_rt;
        op      = int'(inst >> 26);
        src_rs  = int'((inst >> 21) & 32'd31);
        src_rt  = int'((inst >> 16) & 32'd31);
        uses_rs = (op != 2);
        uses_rt = (op == 0) || (op == 43) || (op == 4);
        if (!v || !mr || r == 5'd0) return 1'b0;
        return (uses_rs && int'(r) == src_rs) || (uses_rt && int'(r) == src_rt);
    endfunction

    task automatic test_reset();
        rst_n_i = 1'b0; inst_i = 32'h8C220004; PC_i = 32'h0000_0100;
        flush_i = 1'b0; IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd1;
        tick(); tick();
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst_o, 32'h0); end
        total++; if (PC_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC_o, 32'h0); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (bubble_o !== 1'b1) begin bad++; $display("FAIL reset_bubble got=%b exp=1", bubble_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        IDEX_MemRead_i = 1'b0; rst_n_i = 1'b1; PC_i = 32'h0000_0104;
        tick();
        total++; if (inst_o !== 32'h8C220004) begin bad++; $display("FAIL release_inst got=%h exp=%h", inst_o, 32'h8C220004); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", valid_o); end
        total++; if (PC_o !== 32'h0000_0104) begin bad++; $display("FAIL release_pc got=%h exp=%h", PC_o, 32'h104); end
    endtask

    task automatic test_load_use();
        inst_i = 32'h00441820; PC_i = 32'h0000_0108;
        tick();
        IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd2; inst_i = 32'h8CC50000; PC_i = 32'h0000_010C;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
        total++; if (PCWrite_o !== 1'b0) begin bad++; $display("FAIL lu_pcwrite got=%b exp=0", PCWrite_o); end
        total++; if (bubble_o !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b exp=1", bubble_o); end
        tick();
        total++; if (inst_o !== 32'h00441820) begin bad++; $display("FAIL lu_hold_inst got=%h exp=%h", inst_o, 32'h00441820); end
        total++; if (PC_o !== 32'h0000_0108) begin bad++; $display("FAIL lu_hold_pc got=%h exp=%h", PC_o, 32'h108); end
        IDEX_MemRead_i = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_o); end
        tick();
        total++; if (inst_o !== 32'h8CC50000) begin bad++; $display("FAIL lu_next_inst got=%h exp=%h", inst_o, 32'h8CC50000); end
        total++; if (PC_o !== 32'h0000_010C) begin bad++; $display("FAIL lu_next_pc got=%h exp=%h", PC_o, 32'h10C); end
    endtask

    task automatic test_no_false_stall();
        IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd5;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL nfs_lw_rt got=%b exp=0", stall_o); end
        IDEX_rt_i = 5'd6;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL nfs_lw_rs got=%b exp=1", stall_o); end
        IDEX_MemRead_i = 1'b0; inst_i = 32'h00441820; PC_i = 32'h0000_0110;
        tick();
        IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL nfs_rt_zero got=%b exp=0", stall_o); end
        IDEX_rt_i = 5'd4;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL nfs_rtype_rt got=%b exp=1", stall_o); end
        IDEX_MemRead_i = 1'b0;
    endtask

    task automatic test_flush_beats_stall();
        IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd2;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL fbs_pre_stall got=%b exp=1", stall_o); end
        flush_i = 1'b1; PC_i = 32'h0000_0200; inst_i = 32'h20227FFF;
        tick();
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL fbs_inst got=%h exp=%h", inst_o, 32'h0); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fbs_valid got=%b exp=0", valid_o); end
        total++; if (PC_o !== 32'h0000_0200) begin bad++; $display("FAIL fbs_pc got=%h exp=%h", PC_o, 32'h200); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL fbs_post_stall got=%b exp=0", stall_o); end
        total++; if (bubble_o !== 1'b1) begin bad++; $display("FAIL fbs_bubble got=%b exp=1", bubble_o); end
        flush_i = 1'b0; IDEX_MemRead_i = 1'b0;
    endtask

    task automatic test_sign_ext();
        inst_i = 32'h2022FFFC; PC_i = 32'h0000_0204;
        tick();
        total++; if (imm_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL sext_neg got=%h exp=%h", imm_o, 32'hFFFFFFFC); end
        total++; if (op_o !== 6'h08) begin bad++; $display("FAIL field_op got=%h exp=%h", op_o, 6'h08); end
        total++; if (rs_o !== 5'd1) begin bad++; $display("FAIL field_rs got=%0d exp=1", rs_o); end
        total++; if (rt_o !== 5'd2) begin bad++; $display("FAIL field_rt got=%0d exp=2", rt_o); end
        total++; if (rd_o !== 5'd31) begin bad++; $display("FAIL field_rd got=%0d exp=31", rd_o); end
        inst_i = 32'h20227FFF; PC_i = 32'h0000_0208;
        tick();
        total++; if (imm_o !== 32'h00007FFF) begin bad++; $display("FAIL sext_pos got=%h exp=%h", imm_o, 32'h00007FFF); end
    endtask

    task automatic test_random();
        logic [31:0] m_inst, m_pc;
        bit          m_valid, exp_stall;
        logic [5:0]  ops [7];
        logic [5:0]  op;
        int          sel;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0F};
        m_inst = inst_o; m_pc = PC_o; m_valid = valid_o;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 7));
            op  = (sel == 7) ? 6'($urandom) : ops[sel];
            inst_i = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            PC_i = $urandom;
            flush_i = ($urandom_range(0, 7) == 0);
            IDEX_MemRead_i = $urandom_range(0, 1) == 1;
            IDEX_rt_i = 5'($urandom_range(0, 7));
            rst_n_i = ($urandom_range(0, 39) != 0);
            #1;
            exp_stall = ref_hazard(m_inst, m_valid, IDEX_MemRead_i, IDEX_rt_i);
            total++; if (stall_o !== exp_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_o, exp_stall); end
            total++; if (PCWrite_o !== !exp_stall) begin bad++; $display("FAIL rnd_pcwrite n=%0d got=%b exp=%b", n, PCWrite_o, !exp_stall); end
            total++; if (bubble_o !== (exp_stall || !m_valid)) begin bad++; $display("FAIL rnd_bubble n=%0d got=%b exp=%b", n, bubble_o, exp_stall || !m_valid); end
            total++; if (imm_o !== 32'($signed(m_inst[15:0]))) begin bad++; $display("FAIL rnd_imm n=%0d got=%h exp=%h", n, imm_o, 32'($signed(m_inst[15:0]))); end
            total++; if (rd_o !== 5'((m_inst >> 11) & 32'd31)) begin bad++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, rd_o, (m_inst >> 11) & 32'd31); end
            if (!rst_n_i) begin
                m_inst = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
            end else if (flush_i) begin
                m_inst = 32'h0; m_pc = PC_i; m_valid = 1'b0;
            end else if (!exp_stall) begin
                m_inst = inst_i; m_pc = PC_i; m_valid = 1'b1;
            end
            tick();
            total++; if (inst_o !== m_inst) begin bad++; $display("FAIL rnd_inst n=%0d got=%h exp=%h", n, inst_o, m_inst); end
            total++; if (PC_o !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, PC_o, m_pc); end
            total++; if (valid_o !== m_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, valid_o, m_valid); end
        end
        rst_n_i = 1'b1; flush_i = 1'b0; IDEX_MemRead_i = 1'b0;
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_counters();
        rst_n_i = 1'b0; flush_i = 1'b0; IDEX_MemRead_i = 1'b0;
        tick();
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_rst_stall got=%0d exp=0", stall_cnt_o); end
        total++; if (flush_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_rst_flush got=%0d exp=0", flush_cnt_o); end
        rst_n_i = 1'b1; inst_i = 32'h00441820;
        tick();
        IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd2;
        repeat (3) tick();
        IDEX_MemRead_i = 1'b0; flush_i = 1'b1;
        repeat (2) tick();
        flush_i = 1'b0;
        #1;
        total++; if (stall_cnt_o !== 16'd3) begin bad++; $display("FAIL cnt_stall got=%0d exp=3", stall_cnt_o); end
        total++; if (flush_cnt_o !== 16'd2) begin bad++; $display("FAIL cnt_flush got=%0d exp=2", flush_cnt_o); end
        tick();
        IDEX_MemRead_i = 1'b1;
        repeat (65540) tick();
        total++; if (stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h exp=ffff", stall_cnt_o); end
        IDEX_MemRead_i = 1'b0; rst_n_i = 1'b0;
        tick();
        total++; if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_clear got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
        rst_n_i = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush_beats_stall();
        test_sign_ext();
        test_random();
`ifdef IF_ID_PERF_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage MIPS core, directly upstream of the ID/EX register.
- Latches the fetched instruction and PC+4.
- Splits the held instruction into decode fields for the register file, control unit and ID/EX.
- Integrates load-use hazard detection (stall) and branch/jump flush. Drives PC-hold and the control-bubble select into ID/EX.

Parameters:
- NOP_INST, 32'h00000000, instruction word loaded on reset and flush.
- PC_RST, 32'h00000000, PC_o value after reset.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_n_i  input  1  synchronous active-low reset.
- PC_i  input  32  PC+4 from the IF stage.
- inst_i  input  32  instruction from instruction memory.
- flush_i  input  1  branch taken or jump in ID; squash the current fetch.
- IDEX_MemRead_i  input  1  MemRead bit of the instruction now held in ID/EX.
- IDEX_rt_i  input  5  rt (destination) of the instruction now held in ID/EX.
- PC_o  output  32  registered PC+4.
- inst_o  output  32  registered instruction.
- valid_o  output  1  registered; 0 = bubble or squashed slot.
- op_o  output  6  inst_o[31:26].
- rs_o  output  5  inst_o[25:21].
- rt_o  output  5  inst_o[20:16].
- rd_o  output  5  inst_o[15:11].
- imm_o  output  32  inst_o[15:0] sign-extended.
- stall_o  output  1  combinational load-use hazard; holds PC and IF/ID.
- PCWrite_o  output  1  equals ~stall_o.
- bubble_o  output  1  equals stall_o | ~valid_o; ID/EX control-input mux selects zero.

Behaviour:
- Reset: when rst_n_i=0 at posedge:
  - inst_o<=NOP_INST, PC_o<=PC_RST, valid_o<=0.
  - Counters (if present) <=0.
  - Reset overrides flush and stall and takes effect in the same cycle regardless of pipeline state.
- Update priority at posedge, with rst_n_i=1:
  - flush_i=1: inst_o<=NOP_INST, valid_o<=0, PC_o<=PC_i. Flush beats stall.
  - Otherwise stall_o=1: all registers hold.
  - Otherwise: inst_o<=inst_i, PC_o<=PC_i, valid_o<=1.
- Latency: one cycle from inst_i to inst_o.
- Field outputs are pure slices of inst_o. imm_o = {{16{inst_o[15]}}, inst_o[15:0]}.
- Hazard detection is combinational from registered state and the ID/EX inputs. stall_o=1 iff all of:
  - valid_o=1,
  - IDEX_MemRead_i=1,
  - IDEX_rt_i != 0,
  - and either:
    - IDEX_rt_i==rs_o and op_o != 6'b000010 (j), or
    - IDEX_rt_i==rt_o and op_o is one of 6'b000000 (R-type), 6'b101011 (sw), 6'b000100 (beq).
- Stall duration: a load-use stall lasts exactly one cycle. The bubble enters ID/EX, so IDEX_MemRead_i drops the next cycle. The block needs no internal stall state.
- Simultaneous flush and stall: flush wins, slot becomes invalid, and stall_o deasserts next cycle because valid_o=0.
- NOP_INST with valid_o=0 never stalls, even if its fields match.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cnt_o[15:0]: increments each posedge with rst_n_i=1, stall_o=1, flush_i=0.
  - flush_cnt_o[15:0]: increments each posedge with rst_n_i=1, flush_i=1.
  - Both saturate at 16'hFFFF (no wrap) and clear on reset.
- When undefined, these ports and registers are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n_i=0 for 2 cycles with inst_i=32'h8C220004 -> inst_o=0, PC_o=0, valid_o=0, bubble_o=1, stall_o=0. Release -> next posedge inst_o=32'h8C220004, valid_o=1.
- Load-use on rs:
  - IF/ID holds add $3,$2,$4 (32'h00441820); IDEX_MemRead_i=1, IDEX_rt_i=2.
  - Expect stall_o=1, PCWrite_o=0, bubble_o=1, registers held one cycle.
  - Then drop MemRead -> stall_o=0 and the next inst loads.
- No false stall:
  - IF/ID holds lw $5,0($6) (32'h8CC50000), IDEX_rt_i=5, MemRead=1 -> stall_o=0 (rt not a source for lw).
  - IDEX_rt_i=0 with a matching add -> stall_o=0.
- Flush beats stall: hazard present and flush_i=1 at the same posedge -> inst_o=NOP, valid_o=0, PC_o=PC_i. Next cycle stall_o=0.
- Sign extension: inst 32'h2022FFFC -> imm_o=32'hFFFFFFFC. Inst 32'h20227FFF -> imm_o=32'h00007FFF.
- Counters (IF_ID_PERF_CNT_EN): 3 stall cycles + 2 flushes -> stall_cnt_o=3, flush_cnt_o=2. Preload near 16'hFFFF via a long stall run -> saturates at 16'hFFFF. Reset clears both to 0.
